// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch controller: run/pause/adjust FSM, BCD time digits,
// rollover pulse and a blinking blank mask for the digit being adjusted.
module stopwatch_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       blink_tick,
  input  logic       pause_pulse,
  input  logic       load_pulse,
  input  logic       adj,
  input  logic [1:0] sel,
  input  logic [3:0] num,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       adjusting,
  output logic [3:0] blank,
  output logic       rollover
);

  typedef enum logic [1:0] {PAUSED, RUN, ADJUST} state_t;

  state_t     state;
  state_t     state_next;
  logic       phase;
  logic [3:0] load_val;
  logic       at_max;

  // adj overrides everything; leaving ADJUST always lands in PAUSED
  always_comb begin
    state_next = state;
    if (adj) begin
      state_next = ADJUST;
    end else begin
      case (state)
        PAUSED:  state_next = pause_pulse ? RUN : PAUSED;
        RUN:     state_next = pause_pulse ? PAUSED : RUN;
        ADJUST:  state_next = PAUSED;
        default: state_next = PAUSED;
      endcase
    end
  end

  // sel[0] set means a tens digit, which only goes up to 5
  always_comb begin
    load_val = num;
    if (sel[0]) begin
      if (num > 4'd5) load_val = 4'd5;
    end else begin
      if (num > 4'd9) load_val = 4'd9;
    end
  end

  assign at_max = (sec_ones == 4'd9) && (sec_tens == 4'd5) &&
                  (min_ones == 4'd9) && (min_tens == 4'd5);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PAUSED;
      running   <= 1'b0;
      adjusting <= 1'b0;
      rollover  <= 1'b0;
      phase     <= 1'b0;
      sec_ones  <= 4'd0;
      sec_tens  <= 4'd0;
      min_ones  <= 4'd0;
      min_tens  <= 4'd0;
    end else begin
      state     <= state_next;
      running   <= (state_next == RUN);
      adjusting <= (state_next == ADJUST);
      rollover  <= 1'b0;

      if (state == RUN && tick) begin
        if (at_max) begin
          sec_ones <= 4'd0;
          sec_tens <= 4'd0;
          min_ones <= 4'd0;
          min_tens <= 4'd0;
          rollover <= 1'b1;
        end else if (sec_ones != 4'd9) begin
          sec_ones <= sec_ones + 4'd1;
        end else begin
          sec_ones <= 4'd0;
          if (sec_tens != 4'd5) begin
            sec_tens <= sec_tens + 4'd1;
          end else begin
            sec_tens <= 4'd0;
            if (min_ones != 4'd9) begin
              min_ones <= min_ones + 4'd1;
            end else begin
              min_ones <= 4'd0;
              min_tens <= min_tens + 4'd1;
            end
          end
        end
      end else if (state == ADJUST && load_pulse) begin
        case (sel)
          2'b00:   sec_ones <= load_val;
          2'b01:   sec_tens <= load_val;
          2'b10:   min_ones <= load_val;
          default: min_tens <= load_val;
        endcase
      end

      // entering ADJUST starts the blink with the digit visible
      if (state_next == ADJUST && state != ADJUST) begin
        phase <= 1'b0;
      end else if (blink_tick) begin
        phase <= ~phase;
      end
    end
  end

  always_comb begin
    blank = 4'b0000;
    if (adjusting && phase) blank = 4'b0001 << sel;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed plus randomized bench for stopwatch_ctrl, checked against a
// seconds-count reference model.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       blink_tick;
  logic       pause_pulse;
  logic       load_pulse;
  logic       adj;
  logic [1:0] sel;
  logic [3:0] num;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       adjusting;
  logic [3:0] blank;
  logic       rollover;

  int vectors     = 0;
  int miscompares = 0;

  // reference model: mode 0 paused, 1 running, 2 adjusting; time as total seconds
  int   m_mode;
  int   m_total;
  bit   m_phase;
  bit   m_roll;

  stopwatch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .blink_tick  (blink_tick),
    .pause_pulse (pause_pulse),
    .load_pulse  (load_pulse),
    .adj         (adj),
    .sel         (sel),
    .num         (num),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .min_ones    (min_ones),
    .min_tens    (min_tens),
    .running     (running),
    .adjusting   (adjusting),
    .blank       (blank),
    .rollover    (rollover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode  = 0;
    m_total = 0;
    m_phase = 1'b0;
    m_roll  = 1'b0;
  endtask

  // replace one decimal digit of the displayed time, clamped to its legal range
  task automatic model_load(input int which, input int value);
    int d [4];
    int lim;
    d[0] = m_total % 10;
    d[1] = (m_total / 10) % 6;
    d[2] = (m_total / 60) % 10;
    d[3] = m_total / 600;
    lim  = (which % 2 == 1) ? 5 : 9;
    d[which] = (value > lim) ? lim : value;
    m_total = d[3] * 600 + d[2] * 60 + d[1] * 10 + d[0];
  endtask

  task automatic model_step();
    int nmode;
    m_roll = 1'b0;
    if (m_mode == 1 && tick) begin
      m_total = m_total + 1;
      if (m_total == 3600) begin
        m_total = 0;
        m_roll  = 1'b1;
      end
    end
    if (m_mode == 2 && load_pulse) model_load(int'(sel), int'(num));
    if (adj)              nmode = 2;
    else if (m_mode == 2) nmode = 0;
    else if (pause_pulse) nmode = (m_mode == 0) ? 1 : 0;
    else                  nmode = m_mode;
    if (nmode == 2 && m_mode != 2) m_phase = 1'b0;
    else if (blink_tick)           m_phase = ~m_phase;
    m_mode = nmode;
  endtask

  function automatic logic [15:0] model_time();
    logic [15:0] t;
    t[3:0]   = 4'(m_total % 10);
    t[7:4]   = 4'((m_total / 10) % 6);
    t[11:8]  = 4'((m_total / 60) % 10);
    t[15:12] = 4'(m_total / 600);
    return t;
  endfunction

  task automatic checkOutput(input string tag);
    logic [15:0] obs_time;
    logic [3:0]  exp_blank;
    obs_time  = {min_tens, min_ones, sec_tens, sec_ones};
    exp_blank = (m_mode == 2 && m_phase) ? (4'b0001 << sel) : 4'b0000;
    vectors++;
    assert (obs_time === model_time()) else begin
      miscompares++;
      $error("[TB] FAIL %s time: observed %h expected %h", tag, obs_time, model_time());
    end
    vectors++;
    assert (running === (m_mode == 1)) else begin
      miscompares++;
      $error("[TB] FAIL %s running: observed %b expected %b", tag, running, m_mode == 1);
    end
    vectors++;
    assert (adjusting === (m_mode == 2)) else begin
      miscompares++;
      $error("[TB] FAIL %s adjusting: observed %b expected %b", tag, adjusting, m_mode == 2);
    end
    vectors++;
    assert (rollover === m_roll) else begin
      miscompares++;
      $error("[TB] FAIL %s rollover: observed %b expected %b", tag, rollover, m_roll);
    end
    vectors++;
    assert (blank === exp_blank) else begin
      miscompares++;
      $error("[TB] FAIL %s blank: observed %b expected %b", tag, blank, exp_blank);
    end
  endtask

  task automatic check_time(input string tag, input logic [15:0] expected);
    logic [15:0] obs_time;
    obs_time = {min_tens, min_ones, sec_tens, sec_ones};
    vectors++;
    assert (obs_time === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs_time, expected);
    end
  endtask

  // drive at the falling edge, model the rising edge, check 1 ns after it
  task automatic applyStimulus(input string tag, input bit t, input bit b, input bit p,
                               input bit l, input bit a, input logic [1:0] s,
                               input logic [3:0] n);
    tick        = t;
    blink_tick  = b;
    pause_pulse = p;
    load_pulse  = l;
    adj         = a;
    sel         = s;
    num         = n;
    @(posedge clk);
    model_step();
    #1;
    checkOutput(tag);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; tick = 0; blink_tick = 0; pause_pulse = 0;
    load_pulse = 0; adj = 0; sel = 2'b00; num = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    checkOutput("reset");
    rst = 1'b0;

    applyStimulus("start", 0, 0, 1, 0, 0, 2'b00, 4'd0);
    repeat (3) applyStimulus("count", 1, 0, 0, 0, 0, 2'b00, 4'd0);
    check_time("three_ticks", 16'h0003);

    applyStimulus("load_on_adj_rise", 0, 0, 0, 1, 1, 2'b00, 4'd8);
    check_time("load_ignored", 16'h0003);
    applyStimulus("load_sec_ones", 0, 0, 0, 1, 1, 2'b00, 4'd8);
    check_time("sec_ones_8", 16'h0008);
    applyStimulus("leave_adjust", 1, 0, 0, 0, 0, 2'b00, 4'd0);
    applyStimulus("paused_tick", 1, 0, 0, 0, 0, 2'b00, 4'd0);
    check_time("held", 16'h0008);

    applyStimulus("reenter", 0, 0, 0, 0, 1, 2'b00, 4'd0);
    applyStimulus("clamp_sec_tens", 0, 0, 0, 1, 1, 2'b01, 4'd9);
    applyStimulus("clamp_min_tens", 0, 0, 0, 1, 1, 2'b11, 4'd7);
    check_time("clamped", 16'h5058);
    applyStimulus("load_min_ones", 1, 0, 1, 1, 1, 2'b10, 4'd9);
    applyStimulus("clamp_sec_ones", 0, 0, 0, 1, 1, 2'b00, 4'd15);
    check_time("preload", 16'h5959);
    applyStimulus("exit", 0, 0, 0, 0, 0, 2'b00, 4'd0);
    applyStimulus("run", 0, 0, 1, 1, 0, 2'b00, 4'd3);
    applyStimulus("wrap", 1, 0, 0, 0, 0, 2'b00, 4'd0);
    check_time("wrapped", 16'h0000);
    applyStimulus("roll_drop", 0, 0, 0, 0, 0, 2'b00, 4'd0);

    repeat (9) applyStimulus("to_nine", 1, 0, 0, 0, 0, 2'b00, 4'd0);
    applyStimulus("tick_and_pause", 1, 0, 1, 0, 0, 2'b00, 4'd0);
    check_time("ten", 16'h0010);

    applyStimulus("adj_min_ones", 0, 1, 0, 0, 1, 2'b10, 4'd0);
    applyStimulus("blink_on", 0, 1, 0, 0, 1, 2'b10, 4'd0);
    applyStimulus("blink_off", 0, 1, 0, 0, 1, 2'b10, 4'd0);
    applyStimulus("exit2", 0, 0, 0, 0, 0, 2'b10, 4'd0);
    applyStimulus("run2", 0, 0, 1, 0, 0, 2'b00, 4'd0);
    repeat (2) applyStimulus("run2_tick", 1, 1, 0, 0, 0, 2'b00, 4'd0);

    // reset between edges must clear everything without a clock
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 checkOutput("async_reset");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("restart", 1, 0, 1, 0, 0, 2'b00, 4'd0);
    applyStimulus("from_zero", 1, 0, 0, 0, 0, 2'b00, 4'd0);
    check_time("from_zero_time", 16'h0001);

    for (int i = 0; i < 600; i++) begin
      bit a;
      a = adj;
      if ($urandom_range(0, 19) == 0) a = ~a;
      applyStimulus("random",
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 2) == 0),
                    a,
                    2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
